// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: control bundle between the shift-add sequencer and its datapath.
// Latency: none (wires only).
// Backpressure: none; the sequencer ignores start while an operation is running.
// Ports / signals:
//   start            request a multiply (requester -> sequencer)
//   lsbB, bZero      B register status (datapath -> sequencer)
//   lowWrA/B/P       active-low register write strobes (sequencer -> datapath)
//   selInit, addEn, shiftEn   datapath mux/shift selects (sequencer -> datapath)
//   busy, done, count         operation status (sequencer -> requester)
// Modports: master = sequencer side, slave = datapath/requester side.
interface mult_seq_ctrl_if #(
  parameter int CNTWIDTH = 4
);
  logic                start;
  logic                lsbB;
  logic                bZero;
  logic                lowWrA;
  logic                lowWrB;
  logic                lowWrP;
  logic                selInit;
  logic                addEn;
  logic                shiftEn;
  logic                busy;
  logic                done;
  logic [CNTWIDTH-1:0] count;

  modport master (
    input  start, lsbB, bZero,
    output lowWrA, lowWrB, lowWrP, selInit, addEn, shiftEn, busy, done, count
  );

  modport slave (
    output start, lsbB, bZero,
    input  lowWrA, lowWrB, lowWrP, selInit, addEn, shiftEn, busy, done, count
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for a shift-add multiplier (A, B, P registers in the datapath).
// Latency: done in cycle 2 + 2*DATAWIDTH + popcount(B), counting the LOAD cycle as cycle 1.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        mult_seq_ctrl_if.master: start/lsbB/bZero in; write strobes, selects,
//              busy, done and the processed-bit count out.
// Optional feature: define MULT_EARLY_EXIT_EN to finish as soon as B becomes zero.
// CNTWIDTH must satisfy 2**CNTWIDTH > DATAWIDTH so count can reach DATAWIDTH.
module mult_seq_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNTWIDTH-1:0] LAST_BIT = CNTWIDTH'(DATAWIDTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNTWIDTH-1:0] cnt;

  logic low_wr_a;
  logic low_wr_b;
  logic low_wr_p;
  logic sel_init;
  logic add_en;
  logic shift_en;
  logic busy_q;
  logic done_q;

`ifndef MULT_EARLY_EXIT_EN
  // bZero only matters when early exit is built in.
  logic unused_bzero;
  assign unused_bzero = bus.bZero;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == SHIFT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next state plus outputs decoded purely from the state register, so no
  // input reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    low_wr_a  = 1'b1;
    low_wr_b  = 1'b1;
    low_wr_p  = 1'b1;
    sel_init  = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    busy_q    = 1'b0;
    done_q    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        low_wr_a  = 1'b0;
        low_wr_b  = 1'b0;
        low_wr_p  = 1'b0;
        sel_init  = 1'b1;
        busy_q    = 1'b1;
        state_nxt = TEST;
      end

      TEST: begin
        busy_q = 1'b1;
`ifdef MULT_EARLY_EXIT_EN
        // Remaining iterations would only shift zeros, so the product is final.
        if (bus.bZero) begin
          state_nxt = DONE;
        end else if (bus.lsbB) begin
          state_nxt = ADD;
        end else begin
          state_nxt = SHIFT;
        end
`else
        if (bus.lsbB) begin
          state_nxt = ADD;
        end else begin
          state_nxt = SHIFT;
        end
`endif
      end

      ADD: begin
        low_wr_p  = 1'b0;
        add_en    = 1'b1;
        busy_q    = 1'b1;
        state_nxt = SHIFT;
      end

      SHIFT: begin
        low_wr_a = 1'b0;
        low_wr_b = 1'b0;
        shift_en = 1'b1;
        busy_q   = 1'b1;
        // cnt still holds the pre-increment value here.
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end else begin
          state_nxt = TEST;
        end
      end

      DONE: begin
        done_q    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.lowWrA  = low_wr_a;
  assign bus.lowWrB  = low_wr_b;
  assign bus.lowWrP  = low_wr_p;
  assign bus.selInit = sel_init;
  assign bus.addEn   = add_en;
  assign bus.shiftEn = shift_en;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = cnt;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed bench for mult_seq_ctrl with a behavioural A/B/P datapath.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_seq_ctrl;

  logic clk;
  logic rst;

  mult_seq_ctrl_if #(.CNTWIDTH(4)) bus ();

  mult_seq_ctrl #(.DATAWIDTH(8), .CNTWIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath: A widened to hold the shifted multiplicand, B shifts right.
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] reg_a;
  logic [7:0]  reg_b;
  logic [15:0] reg_p;

  assign bus.lsbB  = reg_b[0];
  assign bus.bZero = (reg_b == 8'h00);

  always @(posedge clk) begin
    if (!bus.lowWrA) reg_a <= bus.selInit ? {8'h00, op_a} : (bus.shiftEn ? (reg_a << 1) : reg_a);
    if (!bus.lowWrB) reg_b <= bus.selInit ? op_b : (bus.shiftEn ? (reg_b >> 1) : reg_b);
    if (!bus.lowWrP) reg_p <= bus.selInit ? 16'h0000 : (bus.addEn ? (reg_p + reg_a) : reg_p);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MULT_EARLY_EXIT_EN
  localparam int EXP_B0_CYC = 3;
  localparam int EXP_B0_CNT = 0;
  localparam int EXP_B1_CYC = 6;
  localparam int EXP_B1_CNT = 1;
`else
  localparam int EXP_B0_CYC = 18;
  localparam int EXP_B0_CNT = 8;
  localparam int EXP_B1_CYC = 19;
  localparam int EXP_B1_CNT = 8;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from the LOAD cycle until done is seen (cycle 1 = LOAD).
  // Returns at the falling edge of the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                        input bit skip_start, input bit pulse_mid,
                        output int done_cyc, output int adds);
    int cyc;
    int prev;
    bit seen;
    bit trace_ok;
    op_a     = a;
    op_b     = b;
    adds     = 0;
    done_cyc = -1;
    prev     = 0;
    seen     = 1'b0;
    trace_ok = 1'b1;
    if (!skip_start) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
    end
    cyc = 1;
    while (!seen && cyc <= 60) begin
      @(negedge clk);
      if (pulse_mid) bus.start = (cyc == 5 || cyc == 12);
      if (cyc == 1)
        check("load_outputs", {27'd0, bus.lowWrA, bus.lowWrB, bus.lowWrP, bus.selInit, bus.busy},
              32'b00011);
      if (cyc >= 2) begin
        if ((int'(bus.count) != prev && int'(bus.count) != prev + 1) || bus.count > 4'd8)
          trace_ok = 1'b0;
        prev = int'(bus.count);
      end
      if (bus.addEn) adds++;
      if (bus.done) begin
        done_cyc = cyc;
        seen     = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (pulse_mid) bus.start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("count_trace", {31'd0, trace_ok}, 32'd1);
  endtask

  // One cycle after done: pulse must be gone, controller idle, count held.
  task automatic check_after_done(input string tag, input logic [3:0] exp_cnt);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus.done, bus.busy}, 32'd0);
    check({tag, "_cnt_hold"}, {28'd0, bus.count}, {28'd0, exp_cnt});
  endtask

  initial begin
    int  dc;
    int  ad;
    bit  found;
    rst       = 1'b1;
    bus.start = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs",
          {23'd0, bus.lowWrA, bus.lowWrB, bus.lowWrP, bus.selInit, bus.addEn, bus.shiftEn,
           bus.busy, bus.done, 1'b0},
          32'b111000000);
    check("reset_count", {28'd0, bus.count}, 32'd0);
    rst = 1'b0;

    // Reset while in ADD (A=3, B=5).
    op_a = 8'd3;
    op_b = 8'd5;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.addEn) found = 1'b1;
    end
    check("reach_add", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midop_reset_outputs",
          {24'd0, bus.lowWrA, bus.lowWrB, bus.lowWrP, bus.selInit, bus.addEn, bus.shiftEn,
           bus.busy, bus.done},
          32'b11100000);
    check("midop_reset_count", {28'd0, bus.count}, 32'd0);

    // A=3, B=5: done in cycle 20, two ADDs, P=15.
    run_op(8'd3, 8'd5, 1'b0, 1'b0, 1'b0, dc, ad);
    check("a3b5_done_cycle", dc, 32'd20);
    check("a3b5_adds", ad, 32'd2);
    check("a3b5_product", {16'd0, reg_p}, 32'd15);
    check("a3b5_count", {28'd0, bus.count}, 32'd8);
    check_after_done("a3b5", 4'd8);

    // A=B=0xFF: worst case, done in cycle 26, eight ADDs.
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, dc, ad);
    check("ff_done_cycle", dc, 32'd26);
    check("ff_adds", ad, 32'd8);
    check("ff_product", {16'd0, reg_p}, 32'hFE01);
    check_after_done("ff", 4'd8);

    // start pulses in cycles 5 and 12 must be ignored (A=3, B=5 again).
    run_op(8'd3, 8'd5, 1'b0, 1'b0, 1'b1, dc, ad);
    check("midstart_done_cycle", dc, 32'd20);
    check("midstart_product", {16'd0, reg_p}, 32'd15);
    check_after_done("midstart", 4'd8);
    repeat (3) @(negedge clk);
    check("midstart_single_done", {30'd0, bus.done, bus.busy}, 32'd0);

    // start held high: two back-to-back A=2, B=3 operations.
    run_op(8'd2, 8'd3, 1'b1, 1'b0, 1'b0, dc, ad);
    check("b2b1_done_cycle", dc, 32'd20);
    check("b2b1_product", {16'd0, reg_p}, 32'd6);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_one_idle", {29'd0, bus.busy, bus.selInit, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    run_op(8'd2, 8'd3, 1'b1, 1'b1, 1'b0, dc, ad);
    check("b2b2_done_cycle", dc, 32'd20);
    check("b2b2_product", {16'd0, reg_p}, 32'd6);
    bus.start = 1'b0;
    check_after_done("b2b2", 4'd8);

    // B=0: early exit finishes in cycle 3, otherwise full 8 iterations.
    run_op(8'd9, 8'd0, 1'b0, 1'b0, 1'b0, dc, ad);
    check("b0_done_cycle", dc, EXP_B0_CYC);
    check("b0_product", {16'd0, reg_p}, 32'd0);
    check("b0_count", {28'd0, bus.count}, EXP_B0_CNT);
    check_after_done("b0", 4'(EXP_B0_CNT));

    // B=1, A=7.
    run_op(8'd7, 8'd1, 1'b0, 1'b0, 1'b0, dc, ad);
    check("b1_done_cycle", dc, EXP_B1_CYC);
    check("b1_adds", ad, 32'd1);
    check("b1_product", {16'd0, reg_p}, 32'd7);
    check("b1_count", {28'd0, bus.count}, EXP_B1_CNT);
    check_after_done("b1", 4'(EXP_B1_CNT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
